decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Registered RV32I decode stage with a valid/ready handshake. It sits between fetch and execute.
//  Decodes the full RV32I base set: OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
//  A 2-entry skid buffer gives full throughput under backpressure. Unknown encodings are flagged illegal.
// PARAMETERS
//  XLEN     32  datapath width; imm_number and pc are sign-extended/carried at XLEN
//  ALUOP_W  8   aluop width; encodings are listed in rv32i_pkg
// PORTS
//  clk         in   1        clock; all state updates on the rising edge
//  rst         in   1        synchronous, active-high reset
//  flush       in   1        drops all buffered entries (branch redirect)
//  in_valid    in   1        instr/in_pc valid
//  in_ready    out  1        stage can accept; registered
//  instr       in   32       instruction word
//  in_pc       in   XLEN     PC of instr
//  out_valid   out  1        decoded bundle valid
//  out_ready   in   1        execute accepts the bundle
//  out_pc      out  XLEN     PC of the bundle
//  rs1_addr    out  5        rs1; 0 when r1_enable=0
//  rs2_addr    out  5        rs2; 0 when r2_enable=0
//  w_addr      out  5        rd; 0 when w_enable=0
//  imm_number  out  XLEN     sign-extended I/S/B/U/J immediate; 0 for R-type
//  aluop       out  ALUOP_W  ALU/compare operation
//  r1_enable, r2_enable, w_enable, imm_enable, pc_enable  out 1 each: operand/writeback selects
//  mem_rd, mem_wr, branch, jump  out 1 each: class flags
//  mem_funct3  out  3        instr[14:12] for LOAD/STORE, else 0
//  illegal     out  1        encoding not in RV32I base
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, every bundle output 0, skid empty. Flush gives the same state 1 cycle later.
//  Latency: accepted at edge N (in_valid&in_ready); the bundle is on the outputs after edge N, stable until out_valid&out_ready.
//  Buffering: main reg drives the outputs; skid reg holds one extra. in_ready = !skid_valid (registered).
//   - accept and (main empty or out_ready): the decoded input goes to main
//   - accept, main full, !out_ready: the input goes to skid; in_ready=0 next cycle
//   - out_ready and skid full: skid moves to main; in_ready=1 next cycle
//   - Throughput is 1/cycle when out_ready is held high. Outputs never change while out_valid & !out_ready.
//  flush wins over all same-cycle events: it clears both entries and discards that cycle's input.
//  aluop: 00 nop, 01 add, 02 sub, 03 sll, 04 slt, 05 sltu, 06 xor, 07 srl, 08 sra, 09 or, 0a and,
//   0b pass-imm (LUI), 0c beq, 0d bne, 0e blt, 0f bge, 10 bltu, 11 bgeu.
//  LOAD/STORE/AUIPC/JAL/JALR use aluop add. AUIPC/JAL set pc_enable. JAL/JALR set jump and write pc+4 to rd.
//  STORE/BRANCH: w_enable=0. Any class: w_enable forced 0 when rd==x0.
//  illegal=1 for any of:
//   - unknown opcode or instr[1:0]!=11
//   - OP funct7 not in {0000000, 0100000 on funct3 000/101}
//   - slli funct7!=0; srli/srai funct7 not in {0000000, 0100000}
//   - BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3>=011; JALR funct3!=0
//  An illegal bundle still flows, with all enables/flags 0 and aluop=00, so execute can trap on it.
// STRUCTURE
//  rv32i_pkg: opcode localparams, aluop encodings, and a packed decoded-bundle struct shared with execute.
//  One sub-module: decode_comb, purely combinational instr -> bundle. decode_stage holds the two bundle
//  regs and the handshake logic.
// TESTING
//  rst high 2 cycles -> out_valid=0, in_ready=1, all outputs 0.
//  0x40208133 (sub x2,x1,x2) then 0xfff00093 (addi x1,x0,-1), out_ready=1:
//   bundles 1 cycle later, aluop 02 then 01, imm 0xffffffff.
//  Stream 4 instrs, out_ready low 3 cycles mid-stream: in_ready drops after 2 accepts; no loss or reorder.
//  0x00000013 (nop addi x0) -> w_enable=0. 0x0000007f -> illegal=1, aluop=00, out_valid=1.
//  0xfe000ee3 (beq, imm -4) -> branch=1, aluop 0c, imm 0xfffffffc, w_enable=0.
//  flush with main+skid full and in_valid high -> next cycle out_valid=0, in_ready=1, input dropped.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, aluop encodings, the decoded bundle handed to execute,
// and immediate/aluop helper functions used by the decoder.
package rv32i_pkg;

  localparam int RV_XLEN    = 32;
  localparam int RV_ALUOP_W = 8;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [RV_ALUOP_W-1:0] ALU_NOP  = 8'h00;
  localparam logic [RV_ALUOP_W-1:0] ALU_ADD  = 8'h01;
  localparam logic [RV_ALUOP_W-1:0] ALU_SUB  = 8'h02;
  localparam logic [RV_ALUOP_W-1:0] ALU_SLL  = 8'h03;
  localparam logic [RV_ALUOP_W-1:0] ALU_SLT  = 8'h04;
  localparam logic [RV_ALUOP_W-1:0] ALU_SLTU = 8'h05;
  localparam logic [RV_ALUOP_W-1:0] ALU_XOR  = 8'h06;
  localparam logic [RV_ALUOP_W-1:0] ALU_SRL  = 8'h07;
  localparam logic [RV_ALUOP_W-1:0] ALU_SRA  = 8'h08;
  localparam logic [RV_ALUOP_W-1:0] ALU_OR   = 8'h09;
  localparam logic [RV_ALUOP_W-1:0] ALU_AND  = 8'h0a;
  localparam logic [RV_ALUOP_W-1:0] ALU_PASS = 8'h0b;
  localparam logic [RV_ALUOP_W-1:0] ALU_BEQ  = 8'h0c;
  localparam logic [RV_ALUOP_W-1:0] ALU_BNE  = 8'h0d;
  localparam logic [RV_ALUOP_W-1:0] ALU_BLT  = 8'h0e;
  localparam logic [RV_ALUOP_W-1:0] ALU_BGE  = 8'h0f;
  localparam logic [RV_ALUOP_W-1:0] ALU_BLTU = 8'h10;
  localparam logic [RV_ALUOP_W-1:0] ALU_BGEU = 8'h11;

  typedef struct packed {
    logic [RV_XLEN-1:0]    pc;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic [4:0]            w_addr;
    logic [RV_XLEN-1:0]    imm_number;
    logic [RV_ALUOP_W-1:0] aluop;
    logic                  r1_enable;
    logic                  r2_enable;
    logic                  w_enable;
    logic                  imm_enable;
    logic                  pc_enable;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  branch;
    logic                  jump;
    logic [2:0]            mem_funct3;
    logic                  illegal;
  } decoded_t;

  function automatic logic [RV_XLEN-1:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'h000};
  endfunction

  function automatic logic [RV_XLEN-1:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // alt selects sub/sra; callers only raise it where that variant exists
  function automatic logic [RV_ALUOP_W-1:0] op_aluop(input logic [2:0] f3, input logic alt);
    logic [RV_ALUOP_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_NOP;
    endcase
    return op;
  endfunction

  function automatic logic [RV_ALUOP_W-1:0] br_aluop(input logic [2:0] f3);
    logic [RV_ALUOP_W-1:0] op;
    case (f3)
      3'b000:  op = ALU_BEQ;
      3'b001:  op = ALU_BNE;
      3'b100:  op = ALU_BLT;
      3'b101:  op = ALU_BGE;
      3'b110:  op = ALU_BLTU;
      3'b111:  op = ALU_BGEU;
      default: op = ALU_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder: instruction word + pc -> decoded bundle.
// Illegal encodings yield a bundle with only pc and illegal set.
module decode_comb
  import rv32i_pkg::*;
(
  input  logic [31:0]        instr,
  input  logic [RV_XLEN-1:0] pc,
  output decoded_t           bundle
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic [4:0] rd_s;
  logic       shift_imm_s;
  decoded_t   raw_s;
  logic       legal_s;

  assign opcode_s    = instr[6:0];
  assign funct3_s    = instr[14:12];
  assign funct7_s    = instr[31:25];
  assign rd_s        = instr[11:7];
  assign shift_imm_s = (funct3_s == 3'b101);

  // Per-class operand selects, flags, aluop, immediate and legality
  always_comb begin
    raw_s   = '0;
    legal_s = 1'b1;
    case (opcode_s)
      OPC_OP: begin
        raw_s.r1_enable = 1'b1;
        raw_s.r2_enable = 1'b1;
        raw_s.w_enable  = 1'b1;
        raw_s.aluop     = op_aluop(funct3_s, funct7_s[5]);
        if (funct7_s == 7'b0000000) begin
          legal_s = 1'b1;
        end else if (funct7_s == 7'b0100000) begin
          legal_s = (funct3_s == 3'b000) || (funct3_s == 3'b101);
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        raw_s.r1_enable  = 1'b1;
        raw_s.w_enable   = 1'b1;
        raw_s.imm_enable = 1'b1;
        raw_s.imm_number = imm_i(instr);
        raw_s.aluop      = op_aluop(funct3_s, shift_imm_s && funct7_s[5]);
        case (funct3_s)
          3'b001:  legal_s = (funct7_s == 7'b0000000);
          3'b101:  legal_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
          default: legal_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        raw_s.r1_enable  = 1'b1;
        raw_s.w_enable   = 1'b1;
        raw_s.imm_enable = 1'b1;
        raw_s.mem_rd     = 1'b1;
        raw_s.imm_number = imm_i(instr);
        raw_s.aluop      = ALU_ADD;
        raw_s.mem_funct3 = funct3_s;
        legal_s = (funct3_s != 3'b011) && (funct3_s != 3'b110) && (funct3_s != 3'b111);
      end
      OPC_STORE: begin
        raw_s.r1_enable  = 1'b1;
        raw_s.r2_enable  = 1'b1;
        raw_s.imm_enable = 1'b1;
        raw_s.mem_wr     = 1'b1;
        raw_s.imm_number = imm_s(instr);
        raw_s.aluop      = ALU_ADD;
        raw_s.mem_funct3 = funct3_s;
        legal_s = (funct3_s < 3'b011);
      end
      OPC_BRANCH: begin
        raw_s.r1_enable  = 1'b1;
        raw_s.r2_enable  = 1'b1;
        raw_s.branch     = 1'b1;
        raw_s.imm_number = imm_b(instr);
        raw_s.aluop      = br_aluop(funct3_s);
        legal_s = (funct3_s != 3'b010) && (funct3_s != 3'b011);
      end
      OPC_LUI: begin
        raw_s.w_enable   = 1'b1;
        raw_s.imm_enable = 1'b1;
        raw_s.imm_number = imm_u(instr);
        raw_s.aluop      = ALU_PASS;
      end
      OPC_AUIPC: begin
        raw_s.w_enable   = 1'b1;
        raw_s.imm_enable = 1'b1;
        raw_s.pc_enable  = 1'b1;
        raw_s.imm_number = imm_u(instr);
        raw_s.aluop      = ALU_ADD;
      end
      OPC_JAL: begin
        raw_s.w_enable   = 1'b1;
        raw_s.imm_enable = 1'b1;
        raw_s.pc_enable  = 1'b1;
        raw_s.jump       = 1'b1;
        raw_s.imm_number = imm_j(instr);
        raw_s.aluop      = ALU_ADD;
      end
      OPC_JALR: begin
        raw_s.r1_enable  = 1'b1;
        raw_s.w_enable   = 1'b1;
        raw_s.imm_enable = 1'b1;
        raw_s.jump       = 1'b1;
        raw_s.imm_number = imm_i(instr);
        raw_s.aluop      = ALU_ADD;
        legal_s = (funct3_s == 3'b000);
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Gate register addresses by their enables; rd==x0 never writes back
  always_comb begin
    bundle    = '0;
    bundle.pc = pc;
    if (legal_s) begin
      bundle          = raw_s;
      bundle.pc       = pc;
      bundle.rs1_addr = raw_s.r1_enable ? instr[19:15] : 5'd0;
      bundle.rs2_addr = raw_s.r2_enable ? instr[24:20] : 5'd0;
      bundle.w_enable = raw_s.w_enable && (rd_s != 5'd0);
      bundle.w_addr   = (raw_s.w_enable && (rd_s != 5'd0)) ? rd_s : 5'd0;
    end else begin
      bundle.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage between fetch and execute: a main bundle register drives
// the outputs and a skid register absorbs one extra entry so backpressure costs no bubbles.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN    = RV_XLEN,
  parameter int ALUOP_W = RV_ALUOP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  output logic [4:0]         w_addr,
  output logic [XLEN-1:0]    imm_number,
  output logic [ALUOP_W-1:0] aluop,
  output logic               r1_enable,
  output logic               r2_enable,
  output logic               w_enable,
  output logic               imm_enable,
  output logic               pc_enable,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               branch,
  output logic               jump,
  output logic [2:0]         mem_funct3,
  output logic               illegal
);

  decoded_t dec_s;
  decoded_t main_r;
  decoded_t skid_r;
  logic     main_valid_r;
  logic     skid_valid_r;
  logic     in_ready_r;
  logic     accept_s;
  logic     main_free_s;

  decode_comb u_decode (
    .instr  (instr),
    .pc     (in_pc),
    .bundle (dec_s)
  );

  assign accept_s    = in_valid && in_ready_r;
  assign main_free_s = !main_valid_r || out_ready;

  // Main/skid occupancy; skid only fills when main is stalled, and always drains first
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
        in_ready_r   <= 1'b1;
      end else if (accept_s) begin
        main_r       <= dec_s;
        main_valid_r <= 1'b1;
        in_ready_r   <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
        in_ready_r   <= 1'b1;
      end
    end else if (accept_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
      in_ready_r   <= 1'b0;
    end else begin
      in_ready_r <= !skid_valid_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = main_valid_r;
  assign out_pc     = main_r.pc;
  assign rs1_addr   = main_r.rs1_addr;
  assign rs2_addr   = main_r.rs2_addr;
  assign w_addr     = main_r.w_addr;
  assign imm_number = main_r.imm_number;
  assign aluop      = main_r.aluop;
  assign r1_enable  = main_r.r1_enable;
  assign r2_enable  = main_r.r2_enable;
  assign w_enable   = main_r.w_enable;
  assign imm_enable = main_r.imm_enable;
  assign pc_enable  = main_r.pc_enable;
  assign mem_rd     = main_r.mem_rd;
  assign mem_wr     = main_r.mem_wr;
  assign branch     = main_r.branch;
  assign jump       = main_r.jump;
  assign mem_funct3 = main_r.mem_funct3;
  assign illegal    = main_r.illegal;

endmodule
